// File: rtl/xbar_perm_seq.sv
// xbar_perm_seq: validates a requested permutation as a bijection, collects generated Benes
// control bits into a slot table, and drives the crossbar from a selected, loaded slot.
module xbar_perm_seq #(
  parameter int unsigned SIZE      = 32,
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned CALC_LAT  = 2,
  localparam int unsigned TAGWIDTH = $clog2(SIZE),
  localparam int unsigned BITWIDTH = (2*TAGWIDTH-1)*SIZE/2,
  localparam int unsigned SLOTW    = $clog2(NUM_SLOTS)
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [SIZE*TAGWIDTH-1:0] req_perm,
  input  logic [SLOTW-1:0]         req_slot,
  output logic [SIZE*TAGWIDTH-1:0] gen_perm,
  input  logic [BITWIDTH-1:0]      gen_ctrl,
  output logic                     resp_valid,
  output logic                     resp_err,
  output logic [SLOTW-1:0]         resp_slot,
  input  logic                     sel_valid,
  input  logic [SLOTW-1:0]         sel_slot,
  output logic [BITWIDTH-1:0]      xbar_ctrl,
  output logic                     xbar_cfg_valid,
  output logic                     busy
);

  localparam int unsigned CNTW = (CALC_LAT > 1) ? $clog2(CALC_LAT) : 1;
  localparam logic [TAGWIDTH-1:0] LAST_K = TAGWIDTH'(SIZE-1);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_CALC, S_RESP} state_t;

  state_t                     r_state, w_next;
  logic [SIZE*TAGWIDTH-1:0]   r_gen_perm;
  logic [SLOTW-1:0]           r_slot;
  logic                       r_err;
  logic [TAGWIDTH-1:0]        r_k;
  logic [SIZE-1:0]            r_seen;
  logic [CNTW-1:0]            r_cnt;
  logic [NUM_SLOTS-1:0]       r_slot_valid;
  logic [BITWIDTH-1:0]        r_table [NUM_SLOTS];
  logic [BITWIDTH-1:0]        r_xbar_ctrl;
  logic                       r_xbar_cfg_valid;

  logic [TAGWIDTH-1:0]        w_elem;
  logic                       w_accept;
  logic                       w_dup;
  logic                       w_last;
  logic                       w_write;
  logic                       w_bypass;

  assign w_elem   = r_gen_perm[r_k*TAGWIDTH +: TAGWIDTH];
  assign w_last   = (r_k == LAST_K);
  assign w_write  = (r_state == S_RESP) && !r_err;
  assign w_bypass = w_write && (sel_slot == r_slot);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_dup    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = S_CHECK;
        end
      end
      S_CHECK: begin
        if (r_seen[w_elem]) begin
          w_dup  = 1'b1;
          w_next = S_RESP;
        end else if (w_last) begin
          w_next = S_CALC;
        end
      end
      S_CALC:  if (r_cnt == '0) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_gen_perm       <= '0;
      r_slot           <= '0;
      r_err            <= 1'b0;
      r_k              <= '0;
      r_seen           <= '0;
      r_cnt            <= '0;
      r_slot_valid     <= '0;
      r_xbar_ctrl      <= '0;
      r_xbar_cfg_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_gen_perm <= req_perm;
        r_slot     <= req_slot;
        r_err      <= 1'b0;
        r_k        <= '0;
        r_seen     <= '0;
      end
      if (r_state == S_CHECK) begin
        if (w_dup) begin
          r_err <= 1'b1;
        end else begin
          r_seen[w_elem] <= 1'b1;
          if (w_last) r_cnt <= CNTW'(CALC_LAT-1);
          else        r_k   <= r_k + 1'b1;
        end
      end
      if (r_state == S_CALC && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      if (w_write) r_slot_valid[r_slot] <= 1'b1;
      // A select racing the table write of the same slot takes the word being written.
      if (sel_valid) begin
        if (w_bypass) begin
          r_xbar_ctrl      <= gen_ctrl;
          r_xbar_cfg_valid <= 1'b1;
        end else if (r_slot_valid[sel_slot]) begin
          r_xbar_ctrl      <= r_table[sel_slot];
          r_xbar_cfg_valid <= 1'b1;
        end
      end
    end
  end

  // Table storage needs no reset: r_slot_valid gates every read.
  always_ff @(posedge CLK) begin
    if (w_write) r_table[r_slot] <= gen_ctrl;
  end

  assign req_ready      = (r_state == S_IDLE);
  assign busy           = (r_state != S_IDLE);
  assign resp_valid     = (r_state == S_RESP);
  assign resp_err       = (r_state == S_RESP) && r_err;
  assign resp_slot      = r_slot;
  assign gen_perm       = r_gen_perm;
  assign xbar_ctrl      = r_xbar_ctrl;
  assign xbar_cfg_valid = r_xbar_cfg_valid;

endmodule

// File: tb/tb_xbar_perm_seq.sv
// Directed bench for xbar_perm_seq: table of load vectors plus hand-written
// sequences for busy-hold, select bypass, slot rewrite and reset abort.
module tb_xbar_perm_seq;

  logic         CLK = 1'b0;
  logic         nRST = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [159:0] req_perm = '0;
  logic [1:0]   req_slot = '0;
  logic [159:0] gen_perm;
  logic [143:0] gen_ctrl = '0;
  logic         resp_valid;
  logic         resp_err;
  logic [1:0]   resp_slot;
  logic         sel_valid = 1'b0;
  logic [1:0]   sel_slot = '0;
  logic [143:0] xbar_ctrl;
  logic         xbar_cfg_valid;
  logic         busy;

  xbar_perm_seq #(.SIZE(32), .NUM_SLOTS(4), .CALC_LAT(2)) dut (
    .CLK(CLK), .nRST(nRST),
    .req_valid(req_valid), .req_ready(req_ready), .req_perm(req_perm), .req_slot(req_slot),
    .gen_perm(gen_perm), .gen_ctrl(gen_ctrl),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_slot(resp_slot),
    .sel_valid(sel_valid), .sel_slot(sel_slot),
    .xbar_ctrl(xbar_ctrl), .xbar_cfg_valid(xbar_cfg_valid), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    bit         rev;
    int         p0;
    int         dup_at;
    logic [1:0] slot;
    int         exp_lat;
    bit         exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [159:0] mk_perm(input bit rev, input int p0, input int dup_at);
    int a [32];
    int t;
    logic [159:0] p;
    for (int i = 0; i < 32; i++) a[i] = rev ? 31 - i : i;
    if (p0 != 0) begin
      t = a[0]; a[0] = a[p0]; a[p0] = t;
    end
    if (dup_at != 0) a[dup_at] = a[0];
    p = '0;
    for (int i = 0; i < 32; i++) p[i*5 +: 5] = 5'(a[i]);
    return p;
  endfunction

  function automatic logic [143:0] ctrl_of(input int n);
    return {9{16'(n * 4099 + 77)}};
  endfunction

  task automatic start_req(input logic [159:0] perm, input logic [1:0] slot, input logic [143:0] ctrl);
    @(negedge CLK);
    req_valid = 1'b1; req_perm = perm; req_slot = slot; gen_ctrl = ctrl;
    chk("ready_in_idle", req_ready, 1);
    @(negedge CLK);
    req_valid = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_resp();
    while (!resp_valid && cyc < 200) begin
      @(negedge CLK);
      cyc++;
    end
  endtask

  task automatic sel_cycle(input logic [1:0] slot);
    sel_valid = 1'b1; sel_slot = slot;
    @(negedge CLK);
    cyc++;
    sel_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, summary not reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [6];
    logic [159:0] perm;
    logic [143:0] ctrl, m_xbar, exp_x;
    int nready, nresp;

    vecs[0] = '{1'b0, 0, 0,  2'd0, 35, 1'b0};  // identity
    vecs[1] = '{1'b0, 3, 5,  2'd2, 7,  1'b1};  // perm[0]=perm[5]=3
    vecs[2] = '{1'b1, 0, 0,  2'd1, 35, 1'b0};  // reversal
    vecs[3] = '{1'b0, 0, 31, 2'd3, 33, 1'b1};  // duplicate at last index
    vecs[4] = '{1'b0, 0, 1,  2'd2, 3,  1'b1};  // duplicate at index 1
    vecs[5] = '{1'b1, 7, 0,  2'd3, 35, 1'b0};  // reversal with a swap

    repeat (3) @(negedge CLK);
    chk("rst_busy", busy, 0);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_err", resp_err, 0);
    chk("rst_xbar", xbar_ctrl, 0);
    chk("rst_cfg_valid", xbar_cfg_valid, 0);
    chk("rst_gen_perm", gen_perm, 0);
    nRST = 1'b1;
    @(negedge CLK);
    chk("post_rst_ready", req_ready, 1);

    m_xbar = '0;
    for (int i = 0; i < 6; i++) begin
      perm = mk_perm(vecs[i].rev, vecs[i].p0, vecs[i].dup_at);
      ctrl = ctrl_of(i + 1);
      start_req(perm, vecs[i].slot, ctrl);
      chk("busy_after_accept", busy, 1);
      wait_resp();
      chk("resp_latency", cyc, vecs[i].exp_lat);
      chk("resp_err", resp_err, vecs[i].exp_err);
      chk("resp_slot", resp_slot, vecs[i].slot);
      chk("gen_perm_stable", gen_perm, perm);
      @(negedge CLK);
      chk("resp_one_cycle", resp_valid, 0);
      sel_cycle(vecs[i].slot);
      exp_x = vecs[i].exp_err ? m_xbar : ctrl;
      chk("select_xbar", xbar_ctrl, exp_x);
      chk("select_cfg_valid", xbar_cfg_valid, 1);
      m_xbar = exp_x;
    end

    // req_valid held through a whole operation: ignored while busy, accepted once idle
    @(negedge CLK);
    req_valid = 1'b1; req_perm = mk_perm(1'b1, 0, 0); req_slot = 2'd1; gen_ctrl = ctrl_of(20);
    @(negedge CLK);
    req_perm = mk_perm(1'b0, 0, 0); req_slot = 2'd0;
    cyc = 1; nready = 0; nresp = 0;
    while (!req_ready && cyc < 100) begin
      nready++;
      if (resp_valid) nresp++;
      @(negedge CLK);
      cyc++;
    end
    chk("hold_ready_low_cycles", nready, 35);
    chk("hold_resp_count", nresp, 1);
    chk("hold_accept_cycle", cyc, 36);
    @(negedge CLK);
    req_valid = 1'b0;
    cyc = 1;
    chk("hold_second_perm", gen_perm, mk_perm(1'b0, 0, 0));
    chk("hold_second_busy", busy, 1);
    wait_resp();
    chk("hold_second_latency", cyc, 35);
    chk("hold_second_slot", resp_slot, 0);

    // select and successful write to slot 1 in the same cycle
    start_req(mk_perm(1'b0, 0, 0), 2'd1, ctrl_of(21));
    wait_resp();
    chk("bypass_resp_err", resp_err, 0);
    sel_cycle(2'd1);
    chk("bypass_xbar", xbar_ctrl, ctrl_of(21));
    chk("bypass_resp_done", resp_valid, 0);

    // rewriting the active slot does not disturb xbar_ctrl until reselected
    start_req(mk_perm(1'b0, 0, 0), 2'd0, ctrl_of(22));
    wait_resp();
    @(negedge CLK);
    sel_cycle(2'd0);
    chk("slot0_active", xbar_ctrl, ctrl_of(22));
    start_req(mk_perm(1'b1, 0, 0), 2'd0, ctrl_of(23));
    while (cyc < 5) begin @(negedge CLK); cyc++; end
    sel_cycle(2'd3);
    chk("select_while_busy", xbar_ctrl, ctrl_of(6));
    sel_cycle(2'd0);
    chk("select_old_slot0", xbar_ctrl, ctrl_of(22));
    wait_resp();
    chk("reload_latency", cyc, 35);
    @(negedge CLK);
    chk("reload_retains_old", xbar_ctrl, ctrl_of(22));
    sel_cycle(2'd0);
    chk("reload_reselect", xbar_ctrl, ctrl_of(23));

    // reset during CALC aborts without response or table write
    start_req(mk_perm(1'b0, 0, 0), 2'd3, ctrl_of(24));
    while (cyc < 33) begin @(negedge CLK); cyc++; end
    chk("calc_busy", busy, 1);
    nRST = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_resp_valid", resp_valid, 0);
    chk("abort_ready", req_ready, 1);
    chk("abort_gen_perm", gen_perm, 0);
    chk("abort_xbar", xbar_ctrl, 0);
    chk("abort_cfg_valid", xbar_cfg_valid, 0);
    @(negedge CLK);
    nRST = 1'b1;
    nresp = 0;
    for (int i = 0; i < 5; i++) begin
      if (resp_valid) nresp++;
      @(negedge CLK);
    end
    chk("abort_no_resp", nresp, 0);
    sel_cycle(2'd3);
    chk("abort_sel_xbar", xbar_ctrl, 0);
    chk("abort_sel_cfg", xbar_cfg_valid, 0);

    // bypass onto a slot that was invalid before this write
    start_req(mk_perm(1'b1, 0, 0), 2'd3, ctrl_of(25));
    wait_resp();
    chk("bypass_inv_latency", cyc, 35);
    sel_cycle(2'd3);
    chk("bypass_inv_xbar", xbar_ctrl, ctrl_of(25));
    chk("bypass_inv_cfg", xbar_cfg_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/xbar_perm_seq.md
XBAR_PERM_SEQ -- requirements
Module: xbar_perm_seq

Interface
REQ-001 SHALL have parameter SIZE, default 32, Benes port count (power of two, at least 4).
REQ-002 SHALL have parameter NUM_SLOTS, default 4, config table depth.
REQ-003 SHALL have parameter CALC_LAT, default 2, cycles allowed for the external control-bit generator (at least 1).
REQ-004 SHALL derive TAGWIDTH = clog2(SIZE), BITWIDTH = (2*TAGWIDTH-1)*SIZE/2 and SLOTW = clog2(NUM_SLOTS).
REQ-005 SHALL use one clock and an active-low reset: the reset is asynchronous, as in the ports below.
REQ-006 CLK  in  1  clock; all state is updated on the rising edge.
REQ-007 nRST  in  1  asynchronous active-low reset.
REQ-008 req_valid  in  1  permutation load request.
REQ-009 req_ready  out  1  request accepted when high together with req_valid.
REQ-010 req_perm  in  SIZE*TAGWIDTH  element i is bits [i*TAGWIDTH +: TAGWIDTH].
REQ-011 req_slot  in  SLOTW  target table slot.
REQ-012 gen_perm  out  SIZE*TAGWIDTH  registered permutation driven to the generator.
REQ-013 gen_ctrl  in  BITWIDTH  generator control bits; valid CALC_LAT cycles after gen_perm is stable.
REQ-014 resp_valid  out  1  one-cycle completion pulse.
REQ-015 resp_err  out  1  qualifies resp_valid; high means the permutation was not a bijection.
REQ-016 resp_slot  out  SLOTW  slot of the completed request.
REQ-017 sel_valid  in  1  request to activate a slot.
REQ-018 sel_slot  in  SLOTW  slot to activate.
REQ-019 xbar_ctrl  out  BITWIDTH  registered control word for the Benes crossbar.
REQ-020 xbar_cfg_valid  out  1  high while xbar_ctrl holds a loaded configuration.
REQ-021 busy  out  1  high in every state except IDLE.

Function
REQ-022 The state machine SHALL have states IDLE, CHECK, CALC, RESP; req_ready = 1 only in IDLE.
REQ-023 On the handshake edge the block SHALL capture req_perm into gen_perm and req_slot into an internal register, clear the seen[SIZE] bitmap, set scan index k = 0, and enter CHECK.
REQ-024 In CHECK, each cycle SHALL test seen[perm[k]]: if already set, go to RESP with err = 1; otherwise set the bit, then increment k, or go to CALC with a CALC_LAT counter when k = SIZE-1.
REQ-025 In CALC, gen_perm SHALL stay stable; after CALC_LAT cycles the block SHALL go to RESP with err = 0.
REQ-026 In RESP, resp_valid SHALL be 1 for exactly one cycle, with resp_err and resp_slot valid; the next state is IDLE.
REQ-027 On the RESP edge with err = 0, the block SHALL write gen_ctrl into table[slot] and set slot_valid[slot]; with err = 1 the table SHALL be unchanged.
REQ-028 Success latency: resp_valid SHALL be asserted in cycle SIZE+CALC_LAT+1 after the handshake edge (cycle 35 for the defaults).
REQ-029 Error latency: a duplicate first detected at index k SHALL produce resp_valid in cycle k+2 after the handshake edge.
REQ-030 gen_perm SHALL change only on a handshake edge.
REQ-031 If sel_valid is high and slot_valid[sel_slot] = 1, then on the next edge xbar_ctrl <= table[sel_slot] and xbar_cfg_valid <= 1.
REQ-032 A select of an invalid slot SHALL be ignored, leaving xbar_ctrl and xbar_cfg_valid unchanged.
REQ-033 Selects SHALL be accepted in every state, independent of the load FSM.
REQ-034 If a select and a RESP write (err = 0) target the same slot in the same cycle, xbar_ctrl SHALL load gen_ctrl (write bypass), including when that slot was previously invalid.
REQ-035 Rewriting the slot currently driving xbar_ctrl SHALL NOT change xbar_ctrl until that slot is selected again.
REQ-036 req_valid while busy SHALL be ignored, and the request SHALL NOT be queued.

Reset
REQ-037 While nRST = 0, the block SHALL force: state IDLE, k = 0, seen = 0, slot_valid = 0, gen_perm = 0, xbar_ctrl = 0, xbar_cfg_valid = 0, resp_valid = 0, resp_err = 0, resp_slot = 0, busy = 0.
REQ-038 A reset in any non-IDLE state SHALL abort the operation with no response pulse and no table write.
REQ-039 Table contents SHALL NOT need a reset because slot_valid gates all reads.

Verification
REQ-040 Identity perm (perm[i] = i) to slot 0 -> resp_valid in cycle 35, resp_err = 0, resp_slot = 0; then sel_slot = 0 -> next cycle xbar_ctrl equals the sampled gen_ctrl and xbar_cfg_valid = 1.
REQ-041 Perm with perm[5] = perm[0] = 3 to slot 2 -> resp_valid in cycle 7, resp_err = 1; a later select of slot 2 leaves xbar_ctrl unchanged.
REQ-042 req_valid held during CHECK of a reversal perm (perm[i] = 31-i) -> req_ready = 0 for 35 cycles and exactly one resp; the second request is accepted in cycle 36.
REQ-043 Select of slot 1 issued in the same cycle as a successful RESP to slot 1 -> xbar_ctrl = the new gen_ctrl one cycle later.
REQ-044 nRST pulsed low during CALC of slot 3 -> no resp_valid, slot_valid = 0, busy = 0; a select of slot 3 afterwards is ignored.
REQ-045 Slot 0 loaded and active, slot 0 reloaded with a different perm -> xbar_ctrl retains the old word until slot 0 is reselected.
